// File: rtl/display_share_arbiter.sv
// Round-robin share of one 4-digit seven-segment scan driver among four requesters, plus scan-rate tick.
// Latency: req to gnt/disp_value is 1 cycle; owner data to disp_value is 1 cycle; owner change inserts 1 blank cycle.
// Backpressure: none; requests are level-sensitive and an owner keeps the grant until release or dwell-expiry preemption.
module display_share_arbiter #(
  parameter int unsigned DWELL    = 16,
  parameter int unsigned SCAN_DIV = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [63:0] data_in,
  output logic [3:0]  gnt,
  output logic [1:0]  owner,
  output logic [15:0] disp_value,
  output logic        disp_valid,
  output logic        scan_tick
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_HANDOFF = 2'd2
  } state_t;

  localparam logic [15:0] DWELL_MAX = 16'(DWELL - 1);
  localparam logic [15:0] SCAN_MAX  = 16'(SCAN_DIV - 1);

  state_t      state_q, state_d;
  logic [3:0]  gnt_q, gnt_d;
  logic [1:0]  owner_q, owner_d;
  logic [15:0] disp_value_q, disp_value_d;
  logic        disp_valid_q, disp_valid_d;
  logic [15:0] dwell_q, dwell_d;
  logic [15:0] scan_cnt_q, scan_cnt_d;
  logic        scan_tick_q, scan_tick_d;

  logic        pick_vld;
  logic [1:0]  pick_idx;
  logic        owner_req;
  logic        others_req;

  // Search starts just after the last owner, so the last owner is always considered last.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
    logic [2:0] res;
    logic [1:0] cand;
    res = 3'b000;
    for (int k = 4; k >= 1; k--) begin
      cand = last + 2'(k);
      if (r[cand]) res = {1'b1, cand};
    end
    return res;
  endfunction

  // Round-robin candidate and owner/contender request status for this cycle.
  always_comb begin
    {pick_vld, pick_idx} = rr_pick(req, owner_q);
    owner_req  = req[owner_q];
    others_req = |(req & ~(4'b0001 << owner_q));
  end

  // Arbitration next-state and registered output values.
  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    owner_d      = owner_q;
    disp_value_d = disp_value_q;
    disp_valid_d = disp_valid_q;
    dwell_d      = dwell_q;
    case (state_q)
      S_GRANT: begin
        if (!owner_req || ((dwell_q == DWELL_MAX) && others_req)) begin
          // Release or preemption: blank the display for one cycle, owner index retained.
          state_d      = S_HANDOFF;
          gnt_d        = 4'b0000;
          disp_valid_d = 1'b0;
          disp_value_d = 16'h0000;
          dwell_d      = 16'h0000;
        end else begin
          disp_value_d = data_in[{owner_q, 4'b0000} +: 16];
          if (dwell_q != DWELL_MAX) dwell_d = dwell_q + 16'd1;
        end
      end
      default: begin
        // IDLE and HANDOFF both pick a fresh owner if anyone is asking.
        if (pick_vld) begin
          state_d      = S_GRANT;
          gnt_d        = 4'b0001 << pick_idx;
          owner_d      = pick_idx;
          disp_value_d = data_in[{pick_idx, 4'b0000} +: 16];
          disp_valid_d = 1'b1;
        end else begin
          state_d      = S_IDLE;
          gnt_d        = 4'b0000;
          disp_value_d = 16'h0000;
          disp_valid_d = 1'b0;
        end
        dwell_d = 16'h0000;
      end
    endcase
  end

  // Free-running scan divider; pulse lands the cycle after the terminal count.
  always_comb begin
    scan_tick_d = (scan_cnt_q == SCAN_MAX);
    scan_cnt_d  = (scan_cnt_q == SCAN_MAX) ? 16'h0000 : scan_cnt_q + 16'd1;
  end

  // State and output registers; reset discards any grant in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      gnt_q        <= 4'b0000;
      owner_q      <= 2'd3;
      disp_value_q <= 16'h0000;
      disp_valid_q <= 1'b0;
      dwell_q      <= 16'h0000;
      scan_cnt_q   <= 16'h0000;
      scan_tick_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      owner_q      <= owner_d;
      disp_value_q <= disp_value_d;
      disp_valid_q <= disp_valid_d;
      dwell_q      <= dwell_d;
      scan_cnt_q   <= scan_cnt_d;
      scan_tick_q  <= scan_tick_d;
    end
  end

  assign gnt        = gnt_q;
  assign owner      = owner_q;
  assign disp_value = disp_value_q;
  assign disp_valid = disp_valid_q;
  assign scan_tick  = scan_tick_q;

endmodule

// File: tb/tb_display_share_arbiter.sv
// Directed bench for display_share_arbiter (DWELL=4, SCAN_DIV=4).
// Inputs are driven and outputs sampled 1ns after each rising edge.
// Each scenario task checks its own expectations inline.
module tb_display_share_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [63:0] data_in;
  logic [3:0]  gnt;
  logic [1:0]  owner;
  logic [15:0] disp_value;
  logic        disp_valid;
  logic        scan_tick;

  int n_cmp;
  int n_err;

  display_share_arbiter #(.DWELL(4), .SCAN_DIV(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .data_in    (data_in),
    .gnt        (gnt),
    .owner      (owner),
    .disp_value (disp_value),
    .disp_valid (disp_valid),
    .scan_tick  (scan_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = 4'b0000;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic exp_tick;
    do_reset();
    data_in = 64'h4444_3333_2222_1111;
    n_cmp++;
    if (gnt !== 4'b0000 || owner !== 2'd3 || disp_value !== 16'h0000 || disp_valid !== 1'b0 || scan_tick !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: gnt=%b owner=%0d disp=%h vld=%b tick=%b, required 0000/3/0000/0/0",
               gnt, owner, disp_value, disp_valid, scan_tick);
    end
    for (int k = 1; k <= 20; k++) begin
      tick();
      exp_tick = (k % 4 == 0);
      n_cmp++;
      if (gnt !== 4'b0000 || disp_valid !== 1'b0 || disp_value !== 16'h0000 || scan_tick !== exp_tick) begin
        n_err++;
        $display("FAIL idle_scan cycle %0d: gnt=%b vld=%b disp=%h tick=%b, required 0000/0/0000/%b",
                 k, gnt, disp_valid, disp_value, scan_tick, exp_tick);
      end
    end
  endtask

  task automatic test_single_owner();
    do_reset();
    data_in = 64'h0;
    data_in[15:0] = 16'h1234;
    req = 4'b0001;
    tick();
    n_cmp++;
    if (gnt !== 4'b0001 || owner !== 2'd0 || disp_value !== 16'h1234 || disp_valid !== 1'b1) begin
      n_err++;
      $display("FAIL single_grant: gnt=%b owner=%0d disp=%h vld=%b, required 0001/0/1234/1",
               gnt, owner, disp_value, disp_valid);
    end
    data_in[15:0] = 16'hBEEF;
    tick();
    n_cmp++;
    if (disp_value !== 16'hBEEF) begin
      n_err++;
      $display("FAIL data_follow: disp=%h, required beef", disp_value);
    end
    for (int k = 0; k < 12; k++) tick();
    n_cmp++;
    if (gnt !== 4'b0001 || disp_valid !== 1'b1 || disp_value !== 16'hBEEF) begin
      n_err++;
      $display("FAIL uncontended_hold: gnt=%b vld=%b disp=%h, required 0001/1/beef", gnt, disp_valid, disp_value);
    end
  endtask

  task automatic test_contention();
    logic [3:0] exp_gnt;
    do_reset();
    data_in = 64'h4444_3333_2222_1111;
    req = 4'b0011;
    for (int k = 0; k < 14; k++) begin
      tick();
      if (k % 5 == 4)            exp_gnt = 4'b0000;
      else if ((k / 5) % 2 == 0) exp_gnt = 4'b0001;
      else                       exp_gnt = 4'b0010;
      n_cmp++;
      if (gnt !== exp_gnt || disp_valid !== (exp_gnt != 4'b0000)) begin
        n_err++;
        $display("FAIL contention cycle %0d: gnt=%b vld=%b, required %b/%b",
                 k, gnt, disp_valid, exp_gnt, (exp_gnt != 4'b0000));
      end
    end
  endtask

  task automatic test_release();
    do_reset();
    data_in = 64'h4444_3333_2222_1111;
    req = 4'b0100;
    tick();
    n_cmp++;
    if (gnt !== 4'b0100 || owner !== 2'd2 || disp_value !== 16'h3333) begin
      n_err++;
      $display("FAIL release_setup: gnt=%b owner=%0d disp=%h, required 0100/2/3333", gnt, owner, disp_value);
    end
    req = 4'b1101;
    tick();
    req = 4'b1001;
    tick();
    n_cmp++;
    if (gnt !== 4'b0000 || disp_valid !== 1'b0 || owner !== 2'd2 || disp_value !== 16'h0000) begin
      n_err++;
      $display("FAIL release_handoff: gnt=%b vld=%b owner=%0d disp=%h, required 0000/0/2/0000",
               gnt, disp_valid, owner, disp_value);
    end
    tick();
    n_cmp++;
    if (gnt !== 4'b1000 || owner !== 2'd3 || disp_value !== 16'h4444) begin
      n_err++;
      $display("FAIL release_next: gnt=%b owner=%0d disp=%h, required 1000/3/4444", gnt, owner, disp_value);
    end
  endtask

  task automatic test_rerequest_order();
    logic [1:0] seq [4];
    logic [3:0] exp_gnt;
    seq[0] = 2'd2; seq[1] = 2'd3; seq[2] = 2'd0; seq[3] = 2'd1;
    do_reset();
    data_in = 64'h4444_3333_2222_1111;
    req = 4'b0010;
    tick();
    req = 4'b0000;
    tick();
    n_cmp++;
    if (gnt !== 4'b0000 || owner !== 2'd1) begin
      n_err++;
      $display("FAIL rerequest_handoff: gnt=%b owner=%0d, required 0000/1", gnt, owner);
    end
    req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      exp_gnt = 4'b0001 << seq[i];
      for (int c = 0; c < 4; c++) begin
        tick();
        n_cmp++;
        if (gnt !== exp_gnt || owner !== seq[i]) begin
          n_err++;
          $display("FAIL rr_order slot %0d cycle %0d: gnt=%b owner=%0d, required %b/%0d",
                   i, c, gnt, owner, exp_gnt, seq[i]);
        end
      end
      tick();
      n_cmp++;
      if (gnt !== 4'b0000 || disp_valid !== 1'b0) begin
        n_err++;
        $display("FAIL rr_blank slot %0d: gnt=%b vld=%b, required 0000/0", i, gnt, disp_valid);
      end
    end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    data_in = 64'h4444_3333_2222_1111;
    req = 4'b0110;
    tick();
    tick();
    tick();
    n_cmp++;
    if (gnt !== 4'b0010 || owner !== 2'd1 || disp_value !== 16'h2222) begin
      n_err++;
      $display("FAIL midreset_setup: gnt=%b owner=%0d disp=%h, required 0010/1/2222", gnt, owner, disp_value);
    end
    reset = 1'b1;
    tick();
    n_cmp++;
    if (gnt !== 4'b0000 || owner !== 2'd3 || disp_value !== 16'h0000 || disp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_clear: gnt=%b owner=%0d disp=%h vld=%b, required 0000/3/0000/0",
               gnt, owner, disp_value, disp_valid);
    end
    reset = 1'b0;
    tick();
    n_cmp++;
    if (gnt !== 4'b0010 || owner !== 2'd1 || disp_valid !== 1'b1 || disp_value !== 16'h2222) begin
      n_err++;
      $display("FAIL midreset_regrant: gnt=%b owner=%0d vld=%b disp=%h, required 0010/1/1/2222",
               gnt, owner, disp_valid, disp_value);
    end
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    reset   = 1'b1;
    req     = 4'b0000;
    data_in = 64'h0;
    test_reset();
    test_single_owner();
    test_contention();
    test_release();
    test_rerequest_order();
    test_reset_mid_grant();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
